// File: rtl/hilo_muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: single-cycle MULT/MULTU/MTHI/MTLO and a
// 32-iteration restoring divider for DIV/DIVU with a final sign-fix cycle.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_quot;
  logic [WIDTH-1:0]  r_divisor;
  logic [WIDTH-1:0]  r_raw_rs;
  logic              r_qneg;
  logic              r_rneg;
  logic              r_dz;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;
  logic              r_busy;
  logic              r_done;

  logic                 w_is_signed;
  logic [2*WIDTH-1:0]   w_a_ext;
  logic [2*WIDTH-1:0]   w_b_ext;
  logic [2*WIDTH-1:0]   w_prod;
  logic                 w_rs_neg;
  logic                 w_rt_neg;
  logic [WIDTH-1:0]     w_rs_mag;
  logic [WIDTH-1:0]     w_rt_mag;
  logic [WIDTH:0]       w_rem_shift;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_sub;

  // op[0] distinguishes the unsigned variant of both MULT and DIV.
  assign w_is_signed = ~op[0];
  assign w_a_ext     = {{WIDTH{w_is_signed & rs_value[WIDTH-1]}}, rs_value};
  assign w_b_ext     = {{WIDTH{w_is_signed & rt_value[WIDTH-1]}}, rt_value};
  assign w_prod      = w_a_ext * w_b_ext;

  assign w_rs_neg = w_is_signed & rs_value[WIDTH-1];
  assign w_rt_neg = w_is_signed & rt_value[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -rs_value : rs_value;
  assign w_rt_mag = w_rt_neg ? -rt_value : rt_value;

  // Restoring step; the difference always fits in WIDTH bits when taken.
  assign w_rem_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
  assign w_sub       = w_rem_shift[WIDTH-1:0] - r_divisor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_raw_rs  <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                r_hi   <= w_prod[2*WIDTH-1:WIDTH];
                r_lo   <= w_prod[WIDTH-1:0];
                r_done <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                r_quot    <= w_rs_mag;
                r_divisor <= w_rt_mag;
                r_qneg    <= w_rs_neg ^ w_rt_neg;
                r_rneg    <= w_rs_neg;
                r_raw_rs  <= rs_value;
                r_dz      <= (rt_value == '0);
                r_rem     <= '0;
                r_cnt     <= '0;
                r_busy    <= 1'b1;
                r_state   <= S_DIV;
              end
              OP_MTHI: begin
                r_hi   <= rs_value;
                r_done <= 1'b1;
              end
              OP_MTLO: begin
                r_lo   <= rs_value;
                r_done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_DIV: begin
          r_rem  <= w_ge ? w_sub : w_rem_shift[WIDTH-1:0];
          r_quot <= {r_quot[WIDTH-2:0], w_ge};
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST_ITER) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_dz) begin
            r_lo <= '1;
            r_hi <= r_raw_rs;
          end else begin
            r_lo <= r_qneg ? -r_quot : r_quot;
            r_hi <= r_rneg ? -r_rem : r_rem;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multiply/divide unit with architectural HI/LO registers for the MIPS CPU datapath. Sits downstream of the register-file read stage, beside the ALU. Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and drives the HI/LO values read by MFHI/MFLO. Multiplies and moves complete in one cycle. Divides use a 32-iteration restoring divider, and `busy` stalls the pipeline while a divide runs.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported; the counter and stated constants assume 32.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  operation request; accepted only on an edge where busy=0.
- op  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops (accepted, no state change, no done).
- rs_value  in  32  operand A (dividend, multiplicand, or MTHI/MTLO source).
- rt_value  in  32  operand B (divisor or multiplier).
- busy  out  1  high while a divide is in flight (state ≠ IDLE).
- done  out  1  one-cycle pulse; hi/lo hold the new result while it is high.
- hi  out  32  HI register (registered output).
- lo  out  32  LO register (registered output).

## Operation
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
- States:
  - IDLE: start accepted here only.
  - DIV: 32 iterations.
  - FIX: sign correction and HI/LO write, then return to IDLE.
- Operands are sampled only on the accepting edge. Later input changes are ignored.
- start while busy=1 is ignored: no queueing, no error. The CPU holds the instruction until busy drops.
- MULT/MULTU: 64-bit product of sign- or zero-extended operands. Written on the accepting edge: hi=product[63:32], lo=product[31:0].
- MTHI: hi=rs_value, lo unchanged. MTLO: lo=rs_value, hi unchanged. Both written on the accepting edge.
- DIV/DIVU on the accept edge:
  - Latch the dividend magnitude (|rs| for DIV, rs for DIVU) and the divisor magnitude.
  - Latch the sign flags: quotient negate = rs[31]^rt[31], remainder negate = rs[31]; both forced 0 for DIVU.
  - Latch the raw dividend and a divisor-zero flag.
  - Clear the partial remainder; state → DIV.
- Each DIV-state edge (restoring step):
  - rem' = {rem[31:0], quot[31]} as a 33-bit value; quot shifts left.
  - If rem' ≥ divisor: rem = rem' − divisor and shift in quotient bit 1; else shift in 0.
  - Counter increments; after the 32nd iteration, state → FIX.
- FIX edge:
  - lo = quotient, negated if its flag is set; hi = remainder, negated if its flag is set.
  - state → IDLE.
- Divisor zero (DIV or DIVU): full latency still spent; lo=0xFFFFFFFF, hi=raw rs_value, no sign fix.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Falls out of magnitude arithmetic; no trap.
- All arithmetic is modulo 2^32 per register; no overflow flags, no exceptions.
- Reset mid-divide aborts immediately: hi/lo=0, busy=0, no done pulse.

## Timing
- Edge E0 accepts start.
- MULT/MULTU/MTHI/MTLO: hi/lo updated after E0; done=1 for the one cycle following E0; busy stays 0. Back-to-back accepts on consecutive edges are legal.
- DIV/DIVU:
  - busy=1 from just after E0 until just after E33 (33 cycles).
  - Iterations occur on edges E1–E32; the FIX write happens at E33.
  - done=1 and final hi/lo valid in the cycle after E33; busy=0 in that same cycle.
  - A new start is accepted at E34 at the earliest.
- During a divide, hi/lo keep their previous values until E33; MFHI/MFLO must not read mid-divide (guaranteed by the stall).
- done is never high for two consecutive cycles from a single operation.

## Test plan
- Reset: assert reset mid-cycle with no clock edge → hi=0, lo=0, busy=0, done=0 immediately.
- Multiply:
  - MULT rs=0xFFFFFFFF, rt=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE, done 1 cycle, busy never high.
  - MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide: DIV rs=0xFFFFFFF9 (−7), rt=2 → busy high exactly 33 cycles, then lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1) with done. Also DIV 7/−2 → lo=0xFFFFFFFD, hi=1.
- Unsigned divide and operand isolation: DIVU rs=0xFFFFFFFF, rt=0x10, then toggle rs/rt and pulse start with op=MTHI mid-divide → lo=0x0FFFFFFF, hi=0xF, MTHI ignored.
- Corner divides:
  - DIV 5/0 → lo=0xFFFFFFFF, hi=5.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
  - Then MTLO rs=0x1234 → lo=0x1234, hi unchanged.
- Reset mid-divide: reset at iteration 10 → busy=0, hi/lo=0, no done. A following DIVU 100/7 completes normally with lo=14, hi=2.
